// File: rtl/rf_dispatch_pkg.sv
// Shared types for the RF command dispatcher: opcodes, error codes, the queued
// command record and the dispatch FSM state encoding.
package rf_dispatch_pkg;

    localparam int CMD_RF_ADDR_W    = 10;
    localparam int CMD_LINE_NUM_W   = 11;
    localparam int CMD_SDRAM_ADDR_W = 32;
    localparam int CMD_TAG_W        = 4;

    typedef enum logic [1:0] {
        OP_LOAD    = 2'b00,
        OP_STORE   = 2'b01,
        OP_MOVE    = 2'b10,
        OP_ILLEGAL = 2'b11
    } rf_op_e;

    typedef enum logic [1:0] {
        ERR_OK         = 2'b00,
        ERR_ILLEGAL_OP = 2'b01,
        ERR_TIMEOUT    = 2'b10
    } rf_err_e;

    typedef struct packed {
        rf_op_e                        op;
        logic [CMD_TAG_W-1:0]          tag;
        logic [CMD_RF_ADDR_W-1:0]      rf_addr;
        logic [CMD_SDRAM_ADDR_W-1:0]   aux_addr;
        logic [CMD_LINE_NUM_W-1:0]     line_num;
    } rf_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_START,
        ST_WAIT,
        ST_RESP
    } disp_state_e;

endpackage

// File: rtl/rf_cmd_fifo.sv
// Command queue in front of the dispatcher. Wrapping pointers carry one extra
// MSB so full and empty are distinguishable without a separate count.
module rf_cmd_fifo
    import rf_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  rf_cmd_t push_data,
    input  logic    pop,
    output rf_cmd_t pop_data,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    rf_cmd_t     mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop frees a slot in the same cycle, so a push while full is still taken.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rf_dispatch.sv
// RF data-movement dispatcher: queues LOAD/STORE/MOVE commands, steers the RF
// RAM port mux, launches the matching engine and returns one tagged response.
module rf_dispatch
    import rf_dispatch_pkg::*;
#(
    parameter int RF_ADDR_W    = CMD_RF_ADDR_W,
    parameter int LINE_NUM_W   = CMD_LINE_NUM_W,
    parameter int SDRAM_ADDR_W = CMD_SDRAM_ADDR_W,
    parameter int TAG_W        = CMD_TAG_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_CYC  = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [TAG_W-1:0]        cmd_tag,
    input  logic [RF_ADDR_W-1:0]    cmd_rf_addr,
    input  logic [SDRAM_ADDR_W-1:0] cmd_aux_addr,
    input  logic [LINE_NUM_W-1:0]   cmd_line_num,
    output logic                    ldst_start,
    output logic                    ldst_is_store,
    output logic [RF_ADDR_W-1:0]    ldst_rf_addr,
    output logic [SDRAM_ADDR_W-1:0] ldst_sdram_addr,
    output logic [LINE_NUM_W-1:0]   ldst_line_num,
    input  logic                    ldst_done,
    output logic                    move_start,
    output logic [RF_ADDR_W-1:0]    move_src,
    output logic [RF_ADDR_W-1:0]    move_dst,
    output logic [LINE_NUM_W-1:0]   move_line_num,
    input  logic                    move_done,
    output logic                    ram_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [1:0]              rsp_err,
    output logic                    busy
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    disp_state_e state;
    rf_cmd_t     fifo_in;
    rf_cmd_t     head;
    rf_cmd_t     act;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        eng_done;
    logic [15:0] tmo_cnt;

    assign fifo_in = '{op: rf_op_e'(cmd_op), tag: cmd_tag, rf_addr: cmd_rf_addr,
                       aux_addr: cmd_aux_addr, line_num: cmd_line_num};
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == ST_IDLE) && !fifo_empty;
    assign busy      = !fifo_empty || (state != ST_IDLE);
    assign eng_done  = (act.op == OP_MOVE) ? move_done : ldst_done;

    rf_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (fifo_in),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            act             <= '0;
            ram_sel         <= 1'b0;
            ldst_start      <= 1'b0;
            ldst_is_store   <= 1'b0;
            ldst_rf_addr    <= '0;
            ldst_sdram_addr <= '0;
            ldst_line_num   <= '0;
            move_start      <= 1'b0;
            move_src        <= '0;
            move_dst        <= '0;
            move_line_num   <= '0;
            tmo_cnt         <= '0;
            rsp_valid       <= 1'b0;
            rsp_tag         <= '0;
            rsp_err         <= ERR_OK;
        end else begin
            ldst_start <= 1'b0;
            move_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        act <= head;
                        if (head.op == OP_ILLEGAL || head.line_num == '0) begin
                            rsp_valid <= 1'b1;
                            rsp_tag   <= head.tag;
                            rsp_err   <= (head.op == OP_ILLEGAL) ? ERR_ILLEGAL_OP : ERR_OK;
                            state     <= ST_RESP;
                        end else begin
                            // Registered here so the mux is already switched throughout SEL.
                            ram_sel <= (head.op != OP_MOVE);
                            state   <= ST_SEL;
                        end
                    end
                end
                ST_SEL: begin
                    if (act.op == OP_MOVE) begin
                        move_start    <= 1'b1;
                        move_src      <= act.rf_addr;
                        move_dst      <= act.aux_addr[RF_ADDR_W-1:0];
                        move_line_num <= act.line_num;
                    end else begin
                        ldst_start      <= 1'b1;
                        ldst_is_store   <= (act.op == OP_STORE);
                        ldst_rf_addr    <= act.rf_addr;
                        ldst_sdram_addr <= act.aux_addr;
                        ldst_line_num   <= act.line_num;
                    end
                    tmo_cnt <= '0;
                    state   <= ST_START;
                end
                ST_START: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done is checked first so it wins over a same-cycle timeout.
                    if (eng_done || tmo_cnt == TMO_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_tag   <= act.tag;
                        rsp_err   <= eng_done ? ERR_OK : ERR_TIMEOUT;
                        state     <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_dispatch.sv
// Directed bench for rf_dispatch with a 16-cycle timeout; expected values are
// hand-derived from the command timeline (IDLE, SEL, START, WAIT, RESP).
module tb_rf_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [3:0]  cmd_tag = '0;
    logic [9:0]  cmd_rf_addr = '0;
    logic [31:0] cmd_aux_addr = '0;
    logic [10:0] cmd_line_num = '0;
    logic        ldst_start, ldst_is_store;
    logic [9:0]  ldst_rf_addr;
    logic [31:0] ldst_sdram_addr;
    logic [10:0] ldst_line_num;
    logic        ldst_done = 1'b0;
    logic        move_start;
    logic [9:0]  move_src, move_dst;
    logic [10:0] move_line_num;
    logic        move_done = 1'b0;
    logic        ram_sel;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_tag;
    logic [1:0]  rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n_ldst = 0;
    int n_move = 0;
    int got;
    int n0;
    logic [3:0] got_tag [8];
    logic [1:0] got_err [8];
    logic       pushed;

    rf_dispatch #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .cmd_rf_addr(cmd_rf_addr), .cmd_aux_addr(cmd_aux_addr), .cmd_line_num(cmd_line_num),
        .ldst_start(ldst_start), .ldst_is_store(ldst_is_store), .ldst_rf_addr(ldst_rf_addr),
        .ldst_sdram_addr(ldst_sdram_addr), .ldst_line_num(ldst_line_num), .ldst_done(ldst_done),
        .move_start(move_start), .move_src(move_src), .move_dst(move_dst),
        .move_line_num(move_line_num), .move_done(move_done), .ram_sel(ram_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ldst_start) n_ldst++;
        if (move_start) n_move++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] tag, input logic [9:0] rf,
                        input logic [31:0] aux, input logic [10:0] lines);
        cmd_op = op; cmd_tag = tag; cmd_rf_addr = rf; cmd_aux_addr = aux; cmd_line_num = lines;
        cmd_valid = 1'b1;
        chk("push_ready", cmd_ready, 1);
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic handshake;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("rsp_cleared", rsp_valid, 0);
    endtask

    // Drains n responses with rsp_ready high; a still-pending cmd_valid is completed too.
    task automatic collect(input int n);
        got = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 80 && got < n; i++) begin
            if (rsp_valid) begin
                got_tag[got] = rsp_tag;
                got_err[got] = rsp_err;
                got++;
            end
            pushed = cmd_valid && cmd_ready;
            tick;
            if (pushed) cmd_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        chk("rsp_count", got, n);
    endtask

    initial begin
        // Reset state
        tick; tick;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ram_sel", ram_sel, 0);
        chk("rst_starts", {ldst_start, move_start}, 0);
        rst_n = 1'b1;
        tick;

        // LOAD tag 3: ram_sel in SEL, single start, fields held, done after 10 cycles
        n0 = n_ldst;
        push(2'b00, 4'd3, 10'h010, 32'h1000, 11'd11);
        tick;
        chk("load_sel_ram_sel", ram_sel, 1);
        chk("load_sel_no_start", ldst_start, 0);
        chk("load_busy", busy, 1);
        tick;
        chk("load_start", ldst_start, 1);
        chk("load_is_store", ldst_is_store, 0);
        chk("load_rf_addr", ldst_rf_addr, 10'h010);
        chk("load_sdram", ldst_sdram_addr, 32'h1000);
        chk("load_lines", ldst_line_num, 11);
        chk("load_no_move", move_start, 0);
        repeat (9) tick;
        chk("load_start_done", ldst_start, 0);
        chk("load_sdram_held", ldst_sdram_addr, 32'h1000);
        chk("load_lines_held", ldst_line_num, 11);
        chk("load_wait_no_rsp", rsp_valid, 0);
        ldst_done = 1'b1;
        tick;
        ldst_done = 1'b0;
        chk("load_rsp_valid", rsp_valid, 1);
        chk("load_rsp_tag", rsp_tag, 3);
        chk("load_rsp_err", rsp_err, 0);
        tick;
        chk("load_rsp_held", {rsp_valid, rsp_tag}, {1'b1, 4'd3});
        handshake;
        chk("load_one_pulse", n_ldst - n0, 1);

        // LOAD tag 1 followed immediately by MOVE tag 2
        n0 = n_move;
        push(2'b00, 4'd1, 10'h020, 32'h2000, 11'd2);
        push(2'b10, 4'd2, 10'd5, 32'd200, 11'd4);
        tick;
        chk("lm_ldst_start", ldst_start, 1);
        tick;
        chk("lm_wait_ram_sel", ram_sel, 1);
        ldst_done = 1'b1;
        tick;
        ldst_done = 1'b0;
        chk("lm_rsp1", {rsp_valid, rsp_tag, rsp_err}, {1'b1, 4'd1, 2'd0});
        handshake;
        chk("lm_idle_ram_sel", ram_sel, 1);
        tick;
        chk("lm_sel_ram_sel", ram_sel, 0);
        chk("lm_sel_no_start", move_start, 0);
        tick;
        chk("lm_move_start", move_start, 1);
        chk("lm_move_src", move_src, 5);
        chk("lm_move_dst", move_dst, 200);
        chk("lm_move_lines", move_line_num, 4);
        chk("lm_no_ldst", ldst_start, 0);
        tick;
        chk("lm_wait_ram_sel0", ram_sel, 0);
        chk("lm_move_pulse_end", move_start, 0);
        move_done = 1'b1;
        tick;
        move_done = 1'b0;
        chk("lm_rsp2", {rsp_valid, rsp_tag, rsp_err}, {1'b1, 4'd2, 2'd0});
        handshake;
        chk("lm_one_move", n_move - n0, 1);

        // Fill: first command stalls in RESP, four more fill the queue
        for (int i = 0; i < 5; i++) push(2'b00, 4'(10 + i), 10'd0, 32'd0, 11'd0);
        chk("full_not_ready", cmd_ready, 0);
        chk("full_rsp_stall", {rsp_valid, rsp_tag}, {1'b1, 4'd10});
        cmd_op = 2'b00; cmd_tag = 4'd15; cmd_line_num = 11'd0; cmd_valid = 1'b1;
        tick;
        chk("full_still_stalled", {cmd_ready, rsp_tag}, {1'b0, 4'd10});
        collect(6);
        for (int i = 0; i < 6; i++) begin
            chk("full_order_tag", got_tag[i], 10 + i);
            chk("full_order_err", got_err[i], 0);
        end
        chk("full_drained_busy", busy, 0);

        // Illegal op then zero-length: no engine starts
        n0 = n_ldst + n_move;
        push(2'b11, 4'd7, 10'd1, 32'd1, 11'd5);
        push(2'b01, 4'd8, 10'd1, 32'd1, 11'd0);
        collect(2);
        chk("ill_tag0", got_tag[0], 7);
        chk("ill_err0", got_err[0], 1);
        chk("zero_tag1", got_tag[1], 8);
        chk("zero_err1", got_err[1], 0);
        chk("ill_no_start", n_ldst + n_move, n0);

        // Timeout 16 cycles after start; stray move_done ignored
        push(2'b00, 4'd5, 10'd3, 32'h40, 11'd3);
        tick;
        tick;
        chk("tmo_start", ldst_start, 1);
        for (int k = 1; k <= 15; k++) begin
            if (k == 5) move_done = 1'b1;
            tick;
            move_done = 1'b0;
            chk("tmo_no_rsp_early", rsp_valid, 0);
        end
        tick;
        chk("tmo_rsp", {rsp_valid, rsp_tag, rsp_err}, {1'b1, 4'd5, 2'd2});
        handshake;

        // Done on the same cycle as timeout wins
        push(2'b01, 4'd6, 10'd3, 32'h80, 11'd1);
        tick;
        tick;
        repeat (15) tick;
        chk("dw_no_rsp_yet", rsp_valid, 0);
        ldst_done = 1'b1;
        tick;
        ldst_done = 1'b0;
        chk("dw_rsp", {rsp_valid, rsp_tag, rsp_err}, {1'b1, 4'd6, 2'd0});
        handshake;

        // Reset during WAIT with a second command queued
        push(2'b00, 4'd9, 10'd7, 32'h100, 11'd2);
        push(2'b01, 4'd10, 10'd8, 32'h200, 11'd2);
        tick;
        tick;
        chk("rw_in_wait", ram_sel, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_ram_sel", ram_sel, 0);
        chk("rw_busy", busy, 0);
        chk("rw_cmd_ready", cmd_ready, 1);
        chk("rw_outputs", {ldst_sdram_addr, ldst_line_num, rsp_valid}, 0);
        tick;
        rst_n = 1'b1;
        repeat (4) tick;
        chk("rw_no_rsp", {rsp_valid, busy}, 0);
        push(2'b01, 4'd11, 10'd9, 32'h300, 11'd1);
        tick;
        chk("rw_next_sel", ram_sel, 1);
        tick;
        chk("rw_next_start", {ldst_start, ldst_is_store, ldst_sdram_addr}, {2'b11, 32'h300});
        tick;
        ldst_done = 1'b1;
        tick;
        ldst_done = 1'b0;
        chk("rw_next_rsp", {rsp_valid, rsp_tag, rsp_err}, {1'b1, 4'd11, 2'd0});
        handshake;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
